// File: rtl/intersection_ctrl.sv
// ---------------------------------------------------------------------------
// intersection_ctrl
//
// Purpose:
//   Two-road traffic intersection controller with a pedestrian walk phase.
//   North-south and east-west greens alternate, and each one is followed by
//   yellow and then an all-red clearance.
//   A pedestrian press is latched. It is then served by a WALK phase that
//   is inserted after the next all-red clearance to expire. After the walk,
//   the road that was due next gets its green.
//
// Ports:
//   clk       in   1  single clock, all state changes on the rising edge
//   rst       in   1  asynchronous, active-low reset
//   ped_req   in   1  pedestrian button, sampled every edge
//   ns_light  out  2  north-south lamp: 00 RED, 01 GREEN, 10 YELLOW
//   ew_light  out  2  east-west lamp, same encoding
//   walk      out  1  pedestrian walk lamp, 1 = walk
//   ped_pend  out  1  latched pedestrian request not yet served
// ---------------------------------------------------------------------------
module intersection_ctrl #(
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_pend
);

    typedef enum logic [2:0] {
        AR_EW,
        NS_G,
        NS_Y,
        AR_NS,
        EW_G,
        EW_Y,
        WALK
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    // The direction register records which all-red phase came before the
    // walk. DIR_NS means the walk followed AR_NS, so east-west is due next.
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // The timer counts down from duration-1 to 0. A duration of 2^CNT_W
    // therefore still fits in CNT_W bits.
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pedPend_q, pedPend_d;
    logic             dir_q, dir_d;

    // Timer reload value for the phase being entered.
    function automatic logic [CNT_W-1:0] loadValue(input state_t s);
        logic [CNT_W-1:0] v;
        v = ALLRED_LD;
        case (s)
            NS_G, EW_G: v = GREEN_LD;
            NS_Y, EW_Y: v = YELLOW_LD;
            WALK:       v = WALK_LD;
            default:    v = ALLRED_LD;
        endcase
        return v;
    endfunction

    // State register. Reset parks the controller in the east-west all-red
    // phase, so the first green after release is north-south and appears
    // ALLRED_T cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= AR_EW;
            timer_q   <= ALLRED_LD;
            pedPend_q <= 1'b0;
            dir_q     <= DIR_NS;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pedPend_q <= pedPend_d;
            dir_q     <= dir_d;
        end
    end

    // Next-state logic. The walk decision looks only at the registered
    // pending flag. A press that arrives on the same edge as an all-red
    // expiry is therefore only latched, and it is served at the next
    // all-red. Entering WALK clears the flag, and this clear takes priority
    // over a press on that same edge: a press while already pending is the
    // same request. Presses sampled during WALK are ignored.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q - 1'b1;
        pedPend_d = pedPend_q | (ped_req && (state_q != WALK));
        dir_d     = dir_q;

        if (timer_q == '0) begin
            case (state_q)
                NS_G:  state_d = NS_Y;
                NS_Y:  state_d = AR_NS;
                AR_NS: begin
                    if (pedPend_q) begin
                        state_d = WALK;
                        dir_d   = DIR_NS;
                    end else begin
                        state_d = EW_G;
                    end
                end
                EW_G:  state_d = EW_Y;
                EW_Y:  state_d = AR_EW;
                AR_EW: begin
                    if (pedPend_q) begin
                        state_d = WALK;
                        dir_d   = DIR_EW;
                    end else begin
                        state_d = NS_G;
                    end
                end
                WALK:    state_d = (dir_q == DIR_NS) ? EW_G : NS_G;
                default: state_d = AR_EW;
            endcase

            timer_d = loadValue(state_d);
            if (state_d == WALK) begin
                pedPend_d = 1'b0;
            end
        end
    end

    // Moore outputs decoded from the registered state only. Every lamp
    // defaults to RED, so at most one road is non-RED at any time, and walk
    // is never shown alongside a non-RED lamp.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        walk     = 1'b0;
        case (state_q)
            NS_G:    ns_light = LAMP_GREEN;
            NS_Y:    ns_light = LAMP_YELLOW;
            EW_G:    ew_light = LAMP_GREEN;
            EW_Y:    ew_light = LAMP_YELLOW;
            WALK:    walk     = 1'b1;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign ped_pend = pedPend_q;

endmodule
